// File: rtl/lcd_timing_controller.sv
// rtl/lcd_timing_controller.sv - LCD/PPU dot, line and mode sequencer with CPU VRAM/OAM arbitration
module lcd_timing_controller #(
    parameter int DOTS_PER_LINE = 456,
    parameter int OAM_DOTS      = 80,
    parameter int DRAW_DOTS     = 172,
    parameter int VISIBLE_LINES = 144,
    parameter int TOTAL_LINES   = 154
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       dot_en,
    input  logic       lcd_enable,
    input  logic [7:0] lyc,
    input  logic [3:0] stat_int_en,
    input  logic       cpu_vram_req,
    input  logic       cpu_oam_req,
    output logic [1:0] mode,
    output logic [7:0] ly,
    output logic [8:0] dot,
    output logic       coincidence,
    output logic       stat_irq,
    output logic       vblank_irq,
    output logic       oam_scan_start,
    output logic       draw_start,
    output logic       line_end,
    output logic       cpu_vram_grant,
    output logic       cpu_oam_grant
);

    if (OAM_DOTS + DRAW_DOTS >= DOTS_PER_LINE || DOTS_PER_LINE > 512 ||
        VISIBLE_LINES >= TOTAL_LINES || TOTAL_LINES > 256) begin : g_bad_params
        $error("lcd_timing_controller: inconsistent timing parameters");
    end

    localparam logic [1:0] MODE_HBLANK = 2'd0;
    localparam logic [1:0] MODE_VBLANK = 2'd1;
    localparam logic [1:0] MODE_OAM    = 2'd2;
    localparam logic [1:0] MODE_DRAW   = 2'd3;

    localparam logic [8:0] DOT_LAST   = 9'(DOTS_PER_LINE - 1);
    localparam logic [8:0] DOT_DRAW   = 9'(OAM_DOTS);
    localparam logic [8:0] DOT_HBLANK = 9'(OAM_DOTS + DRAW_DOTS);
    localparam logic [7:0] LY_LAST    = 8'(TOTAL_LINES - 1);
    localparam logic [7:0] LY_VBLANK  = 8'(VISIBLE_LINES);

    logic [8:0] dot_q, dot_d;
    logic [7:0] ly_q, ly_d;
    logic [1:0] mode_q, mode_d;
    logic       running_q, running_d;
    logic       coincidence_q;
    logic       stat_line_q, stat_line_d;
    logic       stat_irq_q, stat_irq_d;
    logic       vblank_irq_q, vblank_irq_d;
    logic       oam_scan_start_q, oam_scan_start_d;
    logic       draw_start_q, draw_start_d;
    logic       advance;
    logic       stat_cond;

    function automatic logic [1:0] mode_of(input logic [7:0] l, input logic [8:0] d);
        logic [1:0] m;
        if (l >= LY_VBLANK)     m = MODE_VBLANK;
        else if (d < DOT_DRAW)   m = MODE_OAM;
        else if (d < DOT_HBLANK) m = MODE_DRAW;
        else                     m = MODE_HBLANK;
        return m;
    endfunction

    // running_q distinguishes the parked (disabled/not yet strobed) state, which reports mode 0
    always_comb begin
        advance   = lcd_enable & dot_en;
        dot_d     = dot_q;
        ly_d      = ly_q;
        running_d = running_q;
        if (!lcd_enable) begin
            dot_d     = '0;
            ly_d      = '0;
            running_d = 1'b0;
        end else if (dot_en) begin
            running_d = 1'b1;
            if (!running_q) begin
                dot_d = 9'd1;
                ly_d  = '0;
            end else if (dot_q == DOT_LAST) begin
                dot_d = '0;
                ly_d  = (ly_q == LY_LAST) ? '0 : ly_q + 8'd1;
            end else begin
                dot_d = dot_q + 9'd1;
            end
        end
        mode_d = running_d ? mode_of(ly_d, dot_d) : MODE_HBLANK;

        oam_scan_start_d = advance & (~running_q | ((mode_d == MODE_OAM) & (dot_d == '0)));
        draw_start_d     = advance & running_q & (dot_d == DOT_DRAW) & (ly_d < LY_VBLANK);
        vblank_irq_d     = advance & running_q & (dot_d == '0) & (ly_d == LY_VBLANK);

        stat_cond = (coincidence_q & stat_int_en[3]) |
                    ((mode_q == MODE_OAM)    & stat_int_en[2]) |
                    ((mode_q == MODE_VBLANK) & stat_int_en[1]) |
                    ((mode_q == MODE_HBLANK) & stat_int_en[0]);
        stat_line_d = lcd_enable & stat_cond;
        stat_irq_d  = stat_line_d & ~stat_line_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dot_q            <= '0;
            ly_q             <= '0;
            mode_q           <= MODE_HBLANK;
            running_q        <= 1'b0;
            coincidence_q    <= 1'b0;
            stat_line_q      <= 1'b0;
            stat_irq_q       <= 1'b0;
            vblank_irq_q     <= 1'b0;
            oam_scan_start_q <= 1'b0;
            draw_start_q     <= 1'b0;
        end else begin
            dot_q            <= dot_d;
            ly_q             <= ly_d;
            mode_q           <= mode_d;
            running_q        <= running_d;
            coincidence_q    <= (ly_q == lyc);
            stat_line_q      <= stat_line_d;
            stat_irq_q       <= stat_irq_d;
            vblank_irq_q     <= vblank_irq_d;
            oam_scan_start_q <= oam_scan_start_d;
            draw_start_q     <= draw_start_d;
        end
    end

    assign mode           = mode_q;
    assign ly             = ly_q;
    assign dot            = dot_q;
    assign coincidence    = coincidence_q;
    assign stat_irq       = stat_irq_q;
    assign vblank_irq     = vblank_irq_q;
    assign oam_scan_start = oam_scan_start_q;
    assign draw_start     = draw_start_q;
    assign line_end       = advance & running_q & (dot_q == DOT_LAST);

    assign cpu_vram_grant = ~lcd_enable | (mode_q != MODE_DRAW);
    assign cpu_oam_grant  = ~lcd_enable | (mode_q == MODE_HBLANK) | (mode_q == MODE_VBLANK);

    // Bus logic must hold off a request that is not granted; flag it when it does not
    assert property (@(posedge clk) disable iff (!reset_n) !(cpu_vram_req && !cpu_vram_grant))
        else $error("cpu_vram_req while PPU owns VRAM");
    assert property (@(posedge clk) disable iff (!reset_n) !(cpu_oam_req && !cpu_oam_grant))
        else $error("cpu_oam_req while PPU owns OAM");

endmodule

// File: tb/tb_lcd_timing_controller.sv
// tb/tb_lcd_timing_controller.sv - randomized and directed check of lcd_timing_controller against a dot-count model
module tb_lcd_timing_controller;
    localparam int DPL   = 456;
    localparam int OAM   = 80;
    localparam int DRAW  = 172;
    localparam int VIS   = 144;
    localparam int TOT   = 154;
    localparam int FRAME = DPL * TOT;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       dot_en = 1'b0;
    logic       lcd_enable = 1'b0;
    logic [7:0] lyc = 8'd0;
    logic [3:0] stat_int_en = 4'd0;
    logic       cpu_vram_req = 1'b0;
    logic       cpu_oam_req = 1'b0;
    logic [1:0] mode;
    logic [7:0] ly;
    logic [8:0] dot;
    logic       coincidence, stat_irq, vblank_irq, oam_scan_start, draw_start, line_end;
    logic       cpu_vram_grant, cpu_oam_grant;

    lcd_timing_controller dut (
        .clk(clk), .reset_n(reset_n), .dot_en(dot_en), .lcd_enable(lcd_enable),
        .lyc(lyc), .stat_int_en(stat_int_en), .cpu_vram_req(cpu_vram_req), .cpu_oam_req(cpu_oam_req),
        .mode(mode), .ly(ly), .dot(dot), .coincidence(coincidence), .stat_irq(stat_irq),
        .vblank_irq(vblank_irq), .oam_scan_start(oam_scan_start), .draw_start(draw_start),
        .line_end(line_end), .cpu_vram_grant(cpu_vram_grant), .cpu_oam_grant(cpu_oam_grant)
    );

    always #5 clk = ~clk;

    // inputs for the next cycle, applied by step() at the falling edge
    logic       nx_rst = 1'b0, nx_en = 1'b0, nx_dot_en = 1'b0;
    logic [7:0] nx_lyc = 8'd0;
    logic [3:0] nx_sie = 4'd0;

    int checks = 0, passed = 0, fails = 0;
    // model: number of dots taken since the display was (re)enabled; 0 = parked
    int m_steps = 0, sh_steps = 0;
    bit m_coin = 0, m_sline = 0, m_sirq = 0, m_oss = 0, m_ds = 0, m_vb = 0;
    int stat_cnt = 0, vb_cnt = 0;

    function automatic int f_dot(input int s);  return s % DPL; endfunction
    function automatic int f_ly(input int s);   return (s / DPL) % TOT; endfunction
    function automatic int f_mode(input int s);
        if (s == 0) return 0;
        if (f_ly(s) >= VIS) return 1;
        if (f_dot(s) < OAM) return 2;
        if (f_dot(s) < OAM + DRAW) return 3;
        return 0;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else begin
            fails++;
            if (fails <= 30) $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        int  e_mode, n;
        bit  e_vg, e_og, e_le, cond, nl;
        @(negedge clk);
        reset_n     = nx_rst;
        lcd_enable  = nx_en;
        dot_en      = nx_dot_en;
        lyc         = nx_lyc;
        stat_int_en = nx_sie;
        e_mode = f_mode(m_steps);
        e_vg   = !lcd_enable || e_mode != 3;
        e_og   = !lcd_enable || e_mode == 0 || e_mode == 1;
        e_le   = reset_n && lcd_enable && dot_en && m_steps > 0 && f_dot(m_steps) == DPL - 1;
        cpu_vram_req = e_vg && ($urandom_range(0, 1) == 1);
        cpu_oam_req  = e_og && ($urandom_range(0, 1) == 1);
        #1;
        sh_steps = m_steps;
        chk("dot", int'(dot), f_dot(m_steps));
        chk("ly", int'(ly), f_ly(m_steps));
        chk("mode", int'(mode), e_mode);
        chk("coincidence", int'(coincidence), int'(m_coin));
        chk("stat_irq", int'(stat_irq), int'(m_sirq));
        chk("vblank_irq", int'(vblank_irq), int'(m_vb));
        chk("oam_scan_start", int'(oam_scan_start), int'(m_oss));
        chk("draw_start", int'(draw_start), int'(m_ds));
        chk("line_end", int'(line_end), int'(e_le));
        chk("cpu_vram_grant", int'(cpu_vram_grant), int'(e_vg));
        chk("cpu_oam_grant", int'(cpu_oam_grant), int'(e_og));
        if (stat_irq) stat_cnt++;
        if (vblank_irq) vb_cnt++;
        if (!reset_n) begin
            m_steps = 0; m_coin = 0; m_sline = 0; m_sirq = 0; m_oss = 0; m_ds = 0; m_vb = 0;
        end else begin
            cond = (m_coin && stat_int_en[3]) || (e_mode == 2 && stat_int_en[2]) ||
                   (e_mode == 1 && stat_int_en[1]) || (e_mode == 0 && stat_int_en[0]);
            nl      = lcd_enable && cond;
            m_sirq  = nl && !m_sline;
            m_sline = nl;
            m_coin  = (f_ly(m_steps) == int'(lyc));
            m_oss = 0; m_ds = 0; m_vb = 0;
            if (!lcd_enable) m_steps = 0;
            else if (dot_en) begin
                n     = m_steps + 1;
                m_oss = (m_steps == 0) || (f_dot(n) == 0 && f_ly(n) < VIS);
                m_ds  = (f_dot(n) == OAM) && (f_ly(n) < VIS);
                m_vb  = (n % FRAME) == VIS * DPL;
                m_steps = n;
            end
        end
    endtask

    initial begin
        // reset with the display requested on
        nx_rst = 1'b0; nx_en = 1'b1; nx_dot_en = 1'b1; nx_lyc = 8'd5; nx_sie = 4'b1000;
        repeat (3) step();
        chk("lit_reset_dot", int'(dot), 0);
        chk("lit_reset_mode", int'(mode), 0);
        chk("lit_reset_vram_grant", int'(cpu_vram_grant), 1);
        chk("lit_reset_oam_grant", int'(cpu_oam_grant), 1);

        // continuous dots from reset into line 6, mode 3
        nx_rst = 1'b1;
        stat_cnt = 0;
        for (int i = 0; i < 6 * DPL + 201; i++) begin
            step();
            if (sh_steps == 1)   begin chk("lit_first_mode", int'(mode), 2); chk("lit_first_oss", int'(oam_scan_start), 1); end
            if (sh_steps == 79)  chk("lit_mode2_end", int'(mode), 2);
            if (sh_steps == 80)  begin chk("lit_draw_mode", int'(mode), 3); chk("lit_draw_start", int'(draw_start), 1); end
            if (sh_steps == 251) chk("lit_mode3_end", int'(mode), 3);
            if (sh_steps == 252) chk("lit_hblank", int'(mode), 0);
            if (sh_steps == 455) chk("lit_line_end", int'(line_end), 1);
            if (sh_steps == 456) begin chk("lit_ly1", int'(ly), 1); chk("lit_ly1_dot", int'(dot), 0); end
            if (sh_steps == 5 * DPL + 2) chk("lit_lyc_irq", int'(stat_irq), 1);
            if (sh_steps == 6 * DPL) chk("lit_coin_held", int'(coincidence), 1);
            if (sh_steps == 6 * DPL + 1) chk("lit_coin_drop", int'(coincidence), 0);
        end
        chk("lit_stat_count_a", stat_cnt, 1);
        chk("lit_ly6_mode3", int'(mode), 3);
        chk("lit_ly6_vram_grant", int'(cpu_vram_grant), 0);

        // drop the enable mid-draw, then re-enable
        nx_en = 1'b0;
        step();
        chk("lit_dis_vram_grant", int'(cpu_vram_grant), 1);
        chk("lit_dis_oam_grant", int'(cpu_oam_grant), 1);
        step();
        chk("lit_dis_ly", int'(ly), 0);
        chk("lit_dis_dot", int'(dot), 0);
        chk("lit_dis_mode", int'(mode), 0);
        nx_en = 1'b1; nx_dot_en = 1'b0;
        repeat (2) step();
        chk("lit_parked_mode", int'(mode), 0);
        nx_dot_en = 1'b1;
        repeat (2) step();
        chk("lit_reen_mode", int'(mode), 2);
        chk("lit_reen_dot", int'(dot), 1);
        chk("lit_reen_oss", int'(oam_scan_start), 1);

        // one full frame through VBlank and the wrap
        stat_cnt = 0; vb_cnt = 0;
        for (int i = 0; i < FRAME + 2; i++) begin
            step();
            if (sh_steps == VIS * DPL) begin
                chk("lit_vblank_irq", int'(vblank_irq), 1);
                chk("lit_vblank_mode", int'(mode), 1);
                chk("lit_vblank_ly", int'(ly), VIS);
            end
            if (sh_steps == FRAME - 1) begin chk("lit_last_ly", int'(ly), TOT - 1); chk("lit_last_mode", int'(mode), 1); end
            if (sh_steps == FRAME) begin
                chk("lit_wrap_ly", int'(ly), 0);
                chk("lit_wrap_mode", int'(mode), 2);
                chk("lit_wrap_oss", int'(oam_scan_start), 1);
            end
        end
        chk("lit_vblank_count", vb_cnt, 1);
        chk("lit_stat_count_b", stat_cnt, 1);

        // sparse dot strobes with randomized register values and occasional disables
        nx_sie = 4'b1001; nx_lyc = 8'd0;
        for (int i = 0; i < 8000; i++) begin
            nx_dot_en = (i % 4 == 0);
            nx_en     = ($urandom_range(0, 599) != 0);
            if (i % 64 == 63)   nx_lyc = 8'($urandom_range(0, 4));
            if (i % 128 == 127) nx_sie = 4'($urandom_range(0, 15));
            step();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
